vslc_scan_scheduler: RTL and testbench
======================================

// Module: vslc_scan_scheduler
// PURPOSE
//  Sequences the VSLC scan cycle: latch inputs, restart EEPROM program fetch, gate executor
//  instruction strobes until the program end address, then commit outputs. Starts scans
//  periodically (auto mode) or on an external trigger pin. Sits between eeprom_reader, executor
//  and the I/O registers; replaces the ad-hoc end-address restart logic in the top level.
// PARAMETERS
//  ADDR_W       10    program address width (matches start/end header fields)
//  PERIOD_W     16    width of scan period counter
//  WDOG_CYCLES  4096  max clocks in RUN before watchdog fault
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         reset; asynchronous, active-low
//  auto_mode      in   1         1 = periodic scans, 0 = trigger-only
//  trigger_in     in   1         external scan request pin (asynchronous)
//  period         in   PERIOD_W  clocks from scan start to next auto start; 0 = back-to-back
//  end_addr       in   ADDR_W    last program byte address from header; 0 = no program
//  hdr_valid      in   1         header bytes 0..4 loaded since reset
//  rd_ready       in   1         1-cycle pulse per byte delivered by eeprom_reader
//  rd_addr        in   ADDR_W    address of byte accompanying rd_ready
//  fault_clr      in   1         clears FAULT state and sticky flags
//  restart_read   out  1         1-cycle pulse: restart reader at program start
//  latch_inputs   out  1         1-cycle pulse: ui_in -> ui_in_reg, ui_in_reg -> ui_in_prev_reg
//  exec_enable    out  1         AND-gate for executor instr_ready
//  commit_outputs out  1         1-cycle pulse: shadow outputs -> uo_out pins
//  scan_busy      out  1         high in LATCH, RESTART, RUN, COMMIT
//  overrun        out  1         sticky: start request arrived while busy
//  wdog_fault     out  1         sticky: RUN exceeded WDOG_CYCLES
//  scan_count     out  8         completed scans, wraps 255 -> 0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; period_cnt, wdog_cnt, pending, sync flops cleared.
//  - trigger_in: 2-FF synchroniser + edge detect; rising edge = trig_evt (3-cycle latency).
//  - auto_evt = auto_mode && period_cnt >= period. period_cnt: +1 per clk, saturating;
//    cleared on entry to LATCH; frozen in FAULT.
//  - start_req = trig_evt || auto_evt || pending. Simultaneous trig_evt and auto_evt = one scan.
//  - States: IDLE -> LATCH -> RESTART -> RUN -> COMMIT -> IDLE; RUN -> FAULT.
//  - IDLE: if start_req && hdr_valid && end_addr != 0 -> LATCH, clear pending. Otherwise stay;
//    start_req without valid program is dropped (pending not set).
//  - LATCH (1 cycle): latch_inputs=1. RESTART (1 cycle): restart_read=1; wdog_cnt cleared.
//  - RUN: exec_enable=1; wdog_cnt +1 per clk. rd_ready && rd_addr == end_addr -> COMMIT
//    (exec_enable still 1 that cycle so last byte executes). wdog_cnt == WDOG_CYCLES-1 with no
//    end match -> FAULT. End match in the same cycle as watchdog expiry: COMMIT wins.
//  - COMMIT (1 cycle): commit_outputs=1; scan_count +1 -> IDLE.
//  - Busy-state start request (trig_evt or auto_evt edge into true): set pending (1 deep),
//    set overrun. Further requests while pending are merged.
//  - FAULT: exec_enable=0, wdog_fault=1, no pulses, start requests ignored. fault_clr -> IDLE,
//    clears wdog_fault, overrun, pending. fault_clr in non-FAULT states clears overrun only.
//  - rst_n asserted mid-scan: immediate return to IDLE, outputs 0, no commit pulse.
//  - Pulse outputs never overlap; at most one of latch_inputs/restart_read/commit_outputs high.
// TESTING
//  1 auto_mode=1, period=200, end_addr=12, hdr_valid=1 -> latch, restart, RUN, commit; next
//    latch_inputs exactly 200 clks after previous; scan_count increments each scan.
//  2 auto_mode=0, trigger_in rising edge -> latch_inputs 4 clks later (3 sync + 1 IDLE);
//    exec_enable high until rd_ready with rd_addr=12, then single commit_outputs.
//  3 Trigger twice during RUN -> overrun=1, exactly one extra scan starts immediately after COMMIT.
//  4 Reader stalled (no rd_ready) -> FAULT after 4096 RUN clks, wdog_fault=1, exec_enable=0;
//    fault_clr -> IDLE, flags 0, next trigger starts scan.
//  5 end_addr=0 or hdr_valid=0 with trigger -> stays IDLE, no pulses, pending=0.
//  6 rst_n low during RUN -> all outputs 0 next edge asynchronously; no commit_outputs.

Source files
------------

// File: rtl/vslc_scan_scheduler_if.sv
// Scan scheduler link to eeprom_reader, executor and I/O registers.
// master = scheduler side, slave = reader/executor/IO side.
interface vslc_scan_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] end_addr;
  logic              hdr_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              restart_read;
  logic              latch_inputs;
  logic              exec_enable;
  logic              commit_outputs;

  modport master (
    input  end_addr, hdr_valid, rd_ready, rd_addr,
    output restart_read, latch_inputs, exec_enable, commit_outputs
  );

  modport slave (
    output end_addr, hdr_valid, rd_ready, rd_addr,
    input  restart_read, latch_inputs, exec_enable, commit_outputs
  );
endinterface

// File: rtl/vslc_scan_scheduler.sv
// VSLC scan cycle sequencer: latch -> restart fetch -> run to end address -> commit.
// Scans start periodically or on a synchronised trigger edge; RUN is watchdog-guarded.
module vslc_scan_scheduler #(
  parameter int ADDR_W      = 10,
  parameter int PERIOD_W    = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                auto_mode,
  input  logic                trigger_in,
  input  logic [PERIOD_W-1:0] period,
  input  logic                fault_clr,
  vslc_scan_scheduler_if.master bus,
  output logic                scan_busy,
  output logic                overrun,
  output logic                wdog_fault,
  output logic [7:0]          scan_count
);

  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_RESTART, S_RUN, S_COMMIT, S_FAULT
  } state_t;

  state_t state, state_nxt;

  logic                trig_s1, trig_s2, trig_s3, trig_evt;
  logic [PERIOD_W-1:0] period_cnt;
  logic                auto_evt, auto_evt_q, auto_rise;
  logic [WDOG_W-1:0]   wdog_cnt;
  logic                pending;
  logic [ADDR_W-1:0]   last_addr;
  logic                start_req, prog_ok, end_hit, wdog_exp, busy, busy_req, start_scan;
  logic                latch_c, restart_c, exec_c, commit_c;

  assign last_addr  = bus.end_addr;
  assign auto_evt   = auto_mode && (period_cnt >= period);
  assign auto_rise  = auto_evt && !auto_evt_q;
  assign start_req  = trig_evt || auto_evt || pending;
  assign prog_ok    = bus.hdr_valid && (last_addr != '0);
  assign end_hit    = bus.rd_ready && (bus.rd_addr == last_addr);
  assign wdog_exp   = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign busy       = (state == S_LATCH) || (state == S_RESTART) ||
                      (state == S_RUN)   || (state == S_COMMIT);
  assign busy_req   = busy && (trig_evt || auto_rise);
  assign start_scan = (state == S_IDLE) && (state_nxt == S_LATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_c   = 1'b0;
    restart_c = 1'b0;
    exec_c    = 1'b0;
    commit_c  = 1'b0;
    case (state)
      S_IDLE:    if (start_req && prog_ok) state_nxt = S_LATCH;
      S_LATCH: begin
        latch_c   = 1'b1;
        state_nxt = S_RESTART;
      end
      S_RESTART: begin
        restart_c = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // End match outranks watchdog expiry so the last byte still commits.
        exec_c = 1'b1;
        if (end_hit)       state_nxt = S_COMMIT;
        else if (wdog_exp) state_nxt = S_FAULT;
      end
      S_COMMIT: begin
        commit_c  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT:   if (fault_clr) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign bus.latch_inputs   = latch_c;
  assign bus.restart_read   = restart_c;
  assign bus.exec_enable    = exec_c;
  assign bus.commit_outputs = commit_c;
  assign scan_busy          = busy;
  assign wdog_fault         = (state == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_s3    <= 1'b0;
      trig_evt   <= 1'b0;
      auto_evt_q <= 1'b0;
    end else begin
      trig_s1    <= trigger_in;
      trig_s2    <= trig_s1;
      trig_s3    <= trig_s2;
      trig_evt   <= trig_s2 && !trig_s3;
      auto_evt_q <= auto_evt;
    end
  end

  // The start edge loads 1 (the LATCH clock itself), so the next auto start
  // lands exactly 'period' clocks after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (start_scan) begin
      period_cnt <= PERIOD_W'(1);
    end else if ((state != S_FAULT) && (period_cnt != '1)) begin
      period_cnt <= period_cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state == S_RESTART) begin
      wdog_cnt <= '0;
    end else if (state == S_RUN) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end

  // Requests seen in IDLE are consumed or dropped; busy requests merge into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_req)       pending <= 1'b0;
      else if ((state == S_FAULT) && fault_clr) pending <= 1'b0;
      else if (busy_req)                        pending <= 1'b1;

      if (busy_req)       overrun <= 1'b1;
      else if (fault_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_count <= 8'd0;
    end else if (state == S_COMMIT) begin
      scan_count <= scan_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vslc_scan_scheduler.sv
// Bench for vslc_scan_scheduler: vector table for trigger/program cases, hand sequences
// for auto period, overrun, watchdog, end/watchdog tie and mid-scan reset.
module tb_vslc_scan_scheduler;
  localparam int ADDR_W   = 10;
  localparam int PERIOD_W = 16;
  localparam int WDOG     = 4096;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                auto_mode = 1'b0;
  logic                trigger_in = 1'b0;
  logic                fault_clr = 1'b0;
  logic [PERIOD_W-1:0] period = 16'd200;
  logic                scan_busy, overrun, wdog_fault;
  logic [7:0]          scan_count;

  vslc_scan_scheduler_if #(.ADDR_W(ADDR_W)) bus();

  vslc_scan_scheduler #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .WDOG_CYCLES(WDOG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .auto_mode  (auto_mode),
    .trigger_in (trigger_in),
    .period     (period),
    .fault_clr  (fault_clr),
    .bus        (bus),
    .scan_busy  (scan_busy),
    .overrun    (overrun),
    .wdog_fault (wdog_fault),
    .scan_count (scan_count)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         latch_cnt = 0;
  int         rd_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_count = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the trigger and report clocks until latch_inputs (0 = none within 12).
  task automatic fire(output int lat);
    trigger_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.latch_inputs) begin
        lat = i;
        break;
      end
    end
    trigger_in = 1'b0;
  endtask

  // Called on the first RUN sample; counts RUN clocks until COMMIT or exec drops.
  task automatic wait_run(input int budget, output int n, output logic got);
    n = 1;
    got = 1'b0;
    while (n < budget) begin
      step();
      if (bus.commit_outputs) begin
        got = 1'b1;
        break;
      end
      if (!bus.exec_enable) break;
      n++;
    end
  endtask

  // Reader model: walks addresses while exec_enable is high; rewinds on restart_read.
  initial begin
    int rd_cnt;
    rd_cnt = 0;
    bus.rd_ready = 1'b0;
    bus.rd_addr  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.restart_read) rd_cnt = 0;
      bus.rd_ready = 1'b0;
      bus.rd_addr  = '0;
      if (bus.exec_enable) begin
        case (rd_mode)
          1: begin
            bus.rd_ready = 1'b1;
            bus.rd_addr  = ADDR_W'(rd_cnt);
          end
          2: if (rd_cnt % 2 == 0) begin
            bus.rd_ready = 1'b1;
            bus.rd_addr  = ADDR_W'(rd_cnt / 2);
          end
          3: if (rd_cnt == WDOG - 1) begin
            bus.rd_ready = 1'b1;
            bus.rd_addr  = bus.end_addr;
          end
          default: ;
        endcase
        rd_cnt++;
      end
    end
  end

  // Scoreboard pop on each commit, plus pulse exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.latch_inputs) latch_cnt++;
      if (bus.latch_inputs || bus.restart_read || bus.commit_outputs)
        chk("pulse_onehot", int'(bus.latch_inputs) + int'(bus.restart_read) +
            int'(bus.commit_outputs), 1);
      if (bus.commit_outputs) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_commit: got commit with scan_count %0d, want none", scan_count);
        end else begin
          chk("commit_scan_count", scan_count, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    n_err++;
    $display("FAIL timeout: got no finish, want finish within time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  typedef struct {
    logic [ADDR_W-1:0] end_addr;
    logic              hdr;
    int                mode;
    int                exp_lat;
    int                exp_run;
  } vec_t;

  vec_t vt[6];

  initial begin
    int   lat, n, lc;
    logic got;
    logic [7:0] base;

    vt[0] = '{10'd12,  1'b1, 1, 4, 13};
    vt[1] = '{10'd0,   1'b1, 1, 0, 0};
    vt[2] = '{10'd12,  1'b0, 1, 0, 0};
    vt[3] = '{10'd7,   1'b1, 2, 4, 15};
    vt[4] = '{10'd1,   1'b1, 1, 4, 2};
    vt[5] = '{10'd300, 1'b1, 2, 4, 601};

    bus.end_addr  = '0;
    bus.hdr_valid = 1'b0;

    step(3);
    chk("rst_latch",   bus.latch_inputs, 0);
    chk("rst_restart", bus.restart_read, 0);
    chk("rst_exec",    bus.exec_enable, 0);
    chk("rst_commit",  bus.commit_outputs, 0);
    chk("rst_busy",    scan_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wdog",    wdog_fault, 0);
    chk("rst_count",   scan_count, 0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 6; i++) begin
      bus.end_addr  = vt[i].end_addr;
      bus.hdr_valid = vt[i].hdr;
      rd_mode       = vt[i].mode;
      step(2);
      lc = latch_cnt;
      if (vt[i].exp_lat != 0) begin
        exp_q.push_back(exp_count);
        exp_count++;
      end
      fire(lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      if (vt[i].exp_lat != 0) begin
        step();
        chk($sformatf("vec%0d_restart", i), bus.restart_read, 1);
        step();
        chk($sformatf("vec%0d_exec", i), bus.exec_enable, 1);
        wait_run(3000, n, got);
        chk($sformatf("vec%0d_commit", i), got, 1);
        chk($sformatf("vec%0d_run_len", i), n, vt[i].exp_run);
        step();
        chk($sformatf("vec%0d_idle", i), scan_busy, 0);
        chk($sformatf("vec%0d_count", i), scan_count, exp_count);
      end else begin
        chk($sformatf("vec%0d_busy", i), scan_busy, 0);
        chk($sformatf("vec%0d_no_latch", i), latch_cnt - lc, 0);
      end
    end

    // Auto mode: three scans, 200 clocks latch to latch.
    bus.end_addr  = 10'd12;
    bus.hdr_valid = 1'b1;
    rd_mode       = 1;
    base          = exp_count;
    repeat (3) begin
      exp_q.push_back(exp_count);
      exp_count++;
    end
    auto_mode = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.latch_inputs) begin
        got = 1'b1;
        break;
      end
    end
    chk("auto_first_start", got, 1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!bus.latch_inputs && n < 300);
      chk("auto_interval", n, 200);
      chk("auto_scan_count", scan_count, 8'(base + 8'(k) + 8'd1));
    end
    auto_mode = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (scan_busy && n < 40);
    chk("auto_final_count", scan_count, exp_count);

    // Overrun: two triggers during RUN merge into exactly one follow-on scan.
    chk("overrun_clear_before", overrun, 0);
    bus.end_addr = 10'd100;
    rd_mode      = 2;
    repeat (2) begin
      exp_q.push_back(exp_count);
      exp_count++;
    end
    step(3);
    fire(lat);
    chk("ovr_latency", lat, 4);
    step(2);
    repeat (2) begin
      trigger_in = 1'b1;
      step(4);
      trigger_in = 1'b0;
      step(4);
    end
    chk("ovr_still_run", bus.exec_enable, 1);
    chk("ovr_flag", overrun, 1);
    wait_run(500, n, got);
    chk("ovr_commit1", got, 1);
    step();
    chk("ovr_gap_idle", scan_busy, 0);
    step();
    chk("ovr_restart_latch", bus.latch_inputs, 1);
    step(2);
    wait_run(500, n, got);
    chk("ovr_commit2", got, 1);
    step();
    lc = latch_cnt;
    step(60);
    chk("ovr_single_extra", latch_cnt - lc, 0);
    chk("ovr_sticky", overrun, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Watchdog: stalled reader, pending request discarded by fault_clr.
    bus.end_addr = 10'd12;
    rd_mode      = 0;
    step(3);
    fire(lat);
    chk("wd_latency", lat, 4);
    step(2);
    n = 1;
    while (n < 5000) begin
      trigger_in = (n >= 2 && n < 6);
      step();
      if (!bus.exec_enable) break;
      n++;
    end
    trigger_in = 1'b0;
    chk("wd_run_len", n, WDOG);
    chk("wd_fault", wdog_fault, 1);
    chk("wd_exec_off", bus.exec_enable, 0);
    chk("wd_not_busy", scan_busy, 0);
    chk("wd_overrun", overrun, 1);
    step(5);
    chk("wd_sticky", wdog_fault, 1);
    fire(lat);
    chk("wd_ignores_trigger", lat, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("wd_clr_fault", wdog_fault, 0);
    chk("wd_clr_overrun", overrun, 0);
    lc = latch_cnt;
    step(20);
    chk("wd_pending_dropped", latch_cnt - lc, 0);
    exp_q.push_back(exp_count);
    exp_count++;
    rd_mode = 1;
    fire(lat);
    chk("wd_recover_latency", lat, 4);
    step(2);
    wait_run(3000, n, got);
    chk("wd_recover_commit", got, 1);
    chk("wd_recover_run_len", n, 13);
    step();
    chk("wd_recover_count", scan_count, exp_count);

    // End match on the final watchdog clock: COMMIT wins.
    exp_q.push_back(exp_count);
    exp_count++;
    rd_mode = 3;
    step(3);
    fire(lat);
    chk("tie_latency", lat, 4);
    step(2);
    wait_run(5000, n, got);
    chk("tie_commit", got, 1);
    chk("tie_run_len", n, WDOG);
    chk("tie_no_fault", wdog_fault, 0);
    step();
    chk("tie_count", scan_count, exp_count);

    // Reset in the middle of RUN.
    bus.end_addr = 10'd200;
    rd_mode      = 1;
    step(3);
    fire(lat);
    chk("rstrun_latency", lat, 4);
    step(7);
    chk("rstrun_in_run", bus.exec_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("rstrun_exec", bus.exec_enable, 0);
    chk("rstrun_busy", scan_busy, 0);
    chk("rstrun_latch", bus.latch_inputs, 0);
    chk("rstrun_restart", bus.restart_read, 0);
    chk("rstrun_commit", bus.commit_outputs, 0);
    chk("rstrun_count", scan_count, 0);
    exp_count = 8'd0;
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("rstrun_idle", scan_busy, 0);
    chk("rstrun_count_after", scan_count, exp_count);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
